chacha20_poly1305_aead_core: RTL and testbench

//  Iterative ChaCha20 (RFC 8439) stream cipher with a Poly1305 MAC over the ciphertext, on 512-bit blocks.

---
 rtl/chacha20_poly1305_aead_core.sv | 172 +++++++++++++++++
 tb/tb_chacha20_poly1305_aead_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_poly1305_aead_core.sv
// ChaCha20 + Poly1305 AEAD engine with empty AAD. One ChaCha round per cycle and one Poly1305 bit per cycle.
// Latency: init 21, next 21 to data_out then 520 more to ready, done 131. Commands are ignored while ready=0.
module chacha20_poly1305_aead_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         done,
  input  logic         encdec,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [511:0] data_in,
  output logic         ready,
  output logic         valid,
  output logic         tag_ok,
  output logic [511:0] data_out,
  output logic [127:0] tag
);
  typedef enum logic [1:0] {IDLE, CHACHA, POLY, FINAL} state_t;

  localparam logic [130:0] P     = 131'h3_ffff_ffff_ffff_ffff_ffff_ffff_ffff_fffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;

  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] bs128(input logic [127:0] x);
    return {bs32(x[31:0]), bs32(x[63:32]), bs32(x[95:64]), bs32(x[127:96])};
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i + b_i; d = d_i ^ a; d = {d[15:0], d[31:16]};
    c = c_i + d;   b = b_i ^ c; b = {b[19:0], b[31:20]};
    a = a + b;     d = d ^ a;   d = {d[23:0], d[31:24]};
    c = c + d;     b = b ^ c;   b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  // Word 0 is the least significant word; key and nonce words are little-endian.
  function automatic logic [15:0][31:0] st_init(input logic [0:7][31:0] k, input logic [0:2][31:0] n,
                                                input logic [31:0] c);
    return {bs32(n[2]), bs32(n[1]), bs32(n[0]), c,
            bs32(k[7]), bs32(k[6]), bs32(k[5]), bs32(k[4]),
            bs32(k[3]), bs32(k[2]), bs32(k[1]), bs32(k[0]),
            32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  endfunction

  state_t              r_state;
  logic [255:0]        r_key;
  logic [95:0]         r_nonce;
  logic [31:0]         r_ctr, r_blk_ctr;
  logic                r_is_init, r_enc, r_len;
  logic [511:0]        r_data;
  logic [15:0][31:0]   r_x;
  logic [4:0]          r_rnd;
  logic [0:3][127:0]   r_msg;
  logic [1:0]          r_chunk;
  logic [7:0]          r_step;
  logic [130:0]        r_h, r_a;
  logic [127:0]        r_rsh, r_r, r_s;
  logic [129:0]        r_acc;
  logic [63:0]         r_bytes;
  logic                r_ready, r_valid, r_tag_ok;
  logic [511:0]        r_data_out;
  logic [127:0]        r_tag;

  logic [15:0][31:0]   w_col, w_dia, w_st;
  logic [0:15][31:0]   w_ksb;
  logic [511:0]        w_ct;
  logic [127:0]        w_chunk;
  logic [130:0]        w_h, w_fold;
  logic [132:0]        w_sum;
  logic [129:0]        w_red;

  assign {w_col[0], w_col[4], w_col[8],  w_col[12]} = qr(r_x[0], r_x[4], r_x[8],  r_x[12]);
  assign {w_col[1], w_col[5], w_col[9],  w_col[13]} = qr(r_x[1], r_x[5], r_x[9],  r_x[13]);
  assign {w_col[2], w_col[6], w_col[10], w_col[14]} = qr(r_x[2], r_x[6], r_x[10], r_x[14]);
  assign {w_col[3], w_col[7], w_col[11], w_col[15]} = qr(r_x[3], r_x[7], r_x[11], r_x[15]);
  assign {w_dia[0], w_dia[5], w_dia[10], w_dia[15]} = qr(r_x[0], r_x[5], r_x[10], r_x[15]);
  assign {w_dia[1], w_dia[6], w_dia[11], w_dia[12]} = qr(r_x[1], r_x[6], r_x[11], r_x[12]);
  assign {w_dia[2], w_dia[7], w_dia[8],  w_dia[13]} = qr(r_x[2], r_x[7], r_x[8],  r_x[13]);
  assign {w_dia[3], w_dia[4], w_dia[9],  w_dia[14]} = qr(r_x[3], r_x[4], r_x[9],  r_x[14]);

  // Feed-forward input is rebuilt from the stored key/nonce/counter rather than kept in a second state copy.
  assign w_st = st_init(r_key, r_nonce, r_blk_ctr);
  for (genvar g = 0; g < 16; g++) begin : g_ks
    assign w_ksb[g] = bs32(r_x[g] + w_st[g]);
  end
  assign w_ct = r_data ^ w_ksb;

  assign w_chunk = r_len ? {r_bytes, 64'd0} : bs128(r_msg[r_chunk]);
  assign w_h     = {1'b0, r_acc} + {3'b0, w_chunk} + {3'b001, 128'd0};
  assign w_sum   = {1'b0, r_a, 1'b0} + (r_rsh[127] ? {2'b0, r_h} : 133'd0);
  // Fold bits above 2^130 back in as *5; keeps r_a below 2^130+35 so one final subtract suffices.
  assign w_fold  = {1'b0, w_sum[129:0]} + 131'(w_sum[132:130]) * 131'd5;
  assign w_red   = (r_a >= P) ? 130'(r_a - P) : r_a[129:0];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= IDLE;   r_key <= '0;     r_nonce <= '0;   r_ctr <= '0;     r_blk_ctr <= '0;
      r_is_init <= 1'b0; r_enc <= 1'b0;   r_len <= 1'b0;   r_data <= '0;    r_x <= '0;
      r_rnd <= '0;       r_msg <= '0;     r_chunk <= '0;   r_step <= '0;    r_h <= '0;
      r_a <= '0;         r_rsh <= '0;     r_r <= '0;       r_s <= '0;       r_acc <= '0;
      r_bytes <= '0;     r_ready <= 1'b1; r_valid <= 1'b0; r_tag_ok <= 1'b0;
      r_data_out <= '0;  r_tag <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init) begin
            r_key <= key; r_nonce <= nonce; r_blk_ctr <= '0; r_is_init <= 1'b1;
            r_x <= st_init(key, nonce, 32'd0); r_rnd <= '0; r_tag_ok <= 1'b0;
            r_ready <= 1'b0; r_state <= CHACHA;
          end else if (done) begin
            r_len <= 1'b1; r_step <= '0; r_ready <= 1'b0; r_state <= POLY;
          end else if (next) begin
            r_data <= data_in; r_enc <= encdec; r_blk_ctr <= r_ctr; r_is_init <= 1'b0;
            r_x <= st_init(r_key, r_nonce, r_ctr); r_rnd <= '0;
            r_ready <= 1'b0; r_state <= CHACHA;
          end
        end
        CHACHA: begin
          if (r_rnd != 5'd20) begin
            r_x   <= r_rnd[0] ? w_dia : w_col;
            r_rnd <= r_rnd + 5'd1;
          end else if (r_is_init) begin
            r_r   <= bs128({w_ksb[0], w_ksb[1], w_ksb[2], w_ksb[3]}) & CLAMP;
            r_s   <= bs128({w_ksb[4], w_ksb[5], w_ksb[6], w_ksb[7]});
            r_acc <= '0; r_ctr <= 32'd1; r_bytes <= '0;
            r_ready <= 1'b1; r_state <= IDLE;
          end else begin
            r_data_out <= w_ct; r_valid <= 1'b1;
            r_msg   <= r_enc ? w_ct : r_data;
            r_ctr   <= r_ctr + 32'd1;
            r_bytes <= r_bytes + 64'd64;
            r_chunk <= '0; r_len <= 1'b0; r_step <= '0; r_state <= POLY;
          end
        end
        POLY: begin
          r_step <= (r_step == 8'd129) ? 8'd0 : r_step + 8'd1;
          if (r_step == 8'd0) begin
            r_h <= w_h; r_a <= '0; r_rsh <= r_r;
          end else if (r_step != 8'd129) begin
            r_a <= w_fold; r_rsh <= {r_rsh[126:0], 1'b0};
          end else begin
            r_acc <= w_red;
            if (r_len) begin
              r_state <= FINAL;
            end else if (r_chunk == 2'd3) begin
              r_ready <= 1'b1; r_state <= IDLE;
            end else begin
              r_chunk <= r_chunk + 2'd1;
            end
          end
        end
        FINAL: begin
          r_tag <= bs128(r_acc[127:0] + r_s);
          r_tag_ok <= 1'b1; r_ready <= 1'b1; r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready    = r_ready;
  assign valid    = r_valid;
  assign tag_ok   = r_tag_ok;
  assign data_out = r_data_out;
  assign tag      = r_tag;
endmodule

// File: tb/tb_chacha20_poly1305_aead_core.sv
// Directed vectors for the ChaCha20-Poly1305 core, checked against an arithmetic reference model.
module tb_chacha20_poly1305_aead_core;
  logic         clk = 1'b0;
  logic         reset_n, init, next, done, encdec;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [511:0] data_in;
  logic         ready, valid, tag_ok;
  logic [511:0] data_out;
  logic [127:0] tag;

  int n_chk = 0;
  int n_pass = 0;
  int vcount = 0;

  chacha20_poly1305_aead_core dut (
    .clk(clk), .reset_n(reset_n), .init(init), .next(next), .done(done), .encdec(encdec),
    .key(key), .nonce(nonce), .data_in(data_in),
    .ready(ready), .valid(valid), .tag_ok(tag_ok), .data_out(data_out), .tag(tag)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (valid) vcount++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] bs32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] bs128(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127-8*i -: 8];
    return y;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] m_ks(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    logic [31:0] s0[16];
    logic [31:0] x[16];
    logic [31:0] a, b, cc, d;
    logic [511:0] o;
    int qa[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int qb[8] = '{4, 5, 6, 7, 5, 6, 7, 4};
    int qc[8] = '{8, 9, 10, 11, 10, 11, 8, 9};
    int qd[8] = '{12, 13, 14, 15, 15, 12, 13, 14};
    s0[0] = 32'h61707865; s0[1] = 32'h3320646e; s0[2] = 32'h79622d32; s0[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s0[4+j] = bs32(k[255-32*j -: 32]);
    s0[12] = c;
    for (int j = 0; j < 3; j++) s0[13+j] = bs32(n[95-32*j -: 32]);
    x = s0;
    for (int r = 0; r < 10; r++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[qa[q]]; b = x[qb[q]]; cc = x[qc[q]]; d = x[qd[q]];
        a = a + b;  d = rl(d ^ a, 16);
        cc = cc + d; b = rl(b ^ cc, 12);
        a = a + b;  d = rl(d ^ a, 8);
        cc = cc + d; b = rl(b ^ cc, 7);
        x[qa[q]] = a; x[qb[q]] = b; x[qc[q]] = cc; x[qd[q]] = d;
      end
    end
    for (int j = 0; j < 16; j++) o[511-32*j -: 32] = bs32(x[j] + s0[j]);
    return o;
  endfunction

  function automatic logic [127:0] m_tag(input logic [255:0] k, input logic [95:0] n,
                                         input logic [511:0] c0, input logic [511:0] c1, input int nb);
    logic [511:0] ks0, blk;
    logic [263:0] acc, m, r, s, p, hib;
    logic [63:0]  len;
    ks0 = m_ks(k, n, 32'd0);
    r   = 264'(bs128(ks0[511:384]) & 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff);
    s   = 264'(bs128(ks0[383:256]));
    p   = (264'd1 << 130) - 264'd5;
    hib = 264'd1 << 128;
    acc = '0;
    for (int b = 0; b < nb; b++) begin
      blk = (b == 0) ? c0 : c1;
      for (int q = 0; q < 4; q++) begin
        m   = 264'(bs128(blk[511-128*q -: 128]));
        acc = ((acc + m + hib) * r) % p;
      end
    end
    len = 64'(nb) * 64'd64;
    m   = 264'({len, 64'd0});
    acc = ((acc + m + hib) * r) % p;
    acc = acc + s;
    return bs128(acc[127:0]);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!ready && n < budget) begin tick(); n++; end
    check(name, 512'(ready), 512'd1);
  endtask

  task automatic do_init(input logic [255:0] k, input logic [95:0] n);
    int cyc = 0;
    key = k; nonce = n; init = 1'b1;
    tick();
    init = 1'b0;
    while (!ready && cyc < 100) begin tick(); cyc++; end
    check("init_latency", 512'(cyc), 512'd21);
  endtask

  task automatic do_next(input logic [511:0] d, input logic e, output logic [511:0] dout);
    int lat = 0;
    data_in = d; encdec = e; next = 1'b1;
    tick();
    next = 1'b0;
    while (!valid && lat < 100) begin tick(); lat++; end
    check("next_latency", 512'(lat), 512'd21);
    dout = data_out;
    tick();
    check("valid_one_cycle", 512'(valid), 512'd0);
    wait_ready(600, "next_ready");
  endtask

  task automatic do_done(output logic [127:0] t);
    int n = 0;
    done = 1'b1;
    tick();
    done = 1'b0;
    while (!tag_ok && n < 5000) begin tick(); n++; end
    check("tag_ok", 512'(tag_ok), 512'd1);
    check("done_ready", 512'(ready), 512'd1);
    t = tag;
  endtask

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [511:0] d0;
    logic [511:0] d1;
    int           nblk;
    bit           chk_hi;
    logic [127:0] exp_hi;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [511:0] ct[2];
    logic [511:0] pt[2];
    logic [511:0] dout, exp_d;
    logic [127:0] t, t2, exp_t;
    int v0;
    logic [255:0] k1 = {4{64'h0123456789abcdef}};
    logic [95:0]  n1 = 96'h111111112222222233333333;
    logic [511:0] d1 = {8{64'hcafebabedeadbeef}};

    vecs[0] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                96'h000000090000004a00000000, 512'd0, 512'd0, 1, 1'b1,
                128'h10f1e7e4d13b5915500fdd1fa32071c4};
    vecs[1] = '{k1, n1, d1, 512'd0, 1, 1'b0, 128'd0};
    vecs[2] = '{k1, n1, d1, {16{32'h5a5aa5a5}}, 2, 1'b0, 128'd0};
    vecs[3] = '{256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f,
                96'h000000000001020304050607, 512'd0, 512'd0, 0, 1'b0, 128'd0};
    vecs[4] = '{{8{32'hdeadbeef}}, 96'hfffffffeeeeeeeee00000001, {512{1'b1}},
                {16{32'h01234567}}, 2, 1'b0, 128'd0};

    reset_n = 1'b1; init = 1'b0; next = 1'b0; done = 1'b0; encdec = 1'b0;
    key = '0; nonce = '0; data_in = '0;
    tick(); tick();
    check("rst_ready", 512'(ready), 512'd1);
    check("rst_valid", 512'(valid), 512'd0);
    check("rst_tag_ok", 512'(tag_ok), 512'd0);
    check("rst_data_out", data_out, 512'd0);
    check("rst_tag", 512'(tag), 512'd0);
    reset_n = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      pt[0] = vecs[v].d0; pt[1] = vecs[v].d1;
      ct[0] = '0; ct[1] = '0;
      do_init(vecs[v].key, vecs[v].nonce);
      v0 = vcount;
      for (int b = 0; b < vecs[v].nblk; b++) begin
        do_next(pt[b], 1'b1, dout);
        exp_d = pt[b] ^ m_ks(vecs[v].key, vecs[v].nonce, 32'(b + 1));
        check("enc_data_out", dout, exp_d);
        if (vecs[v].chk_hi) check("rfc_ks_hi", 512'(dout[511:384]), 512'(vecs[v].exp_hi));
        ct[b] = dout;
      end
      do_done(t);
      exp_t = m_tag(vecs[v].key, vecs[v].nonce, ct[0], ct[1], vecs[v].nblk);
      check("enc_tag", 512'(t), 512'(exp_t));
      check("valid_count", 512'(vcount - v0), 512'(vecs[v].nblk));
      do_init(vecs[v].key, vecs[v].nonce);
      for (int b = 0; b < vecs[v].nblk; b++) begin
        do_next(ct[b], 1'b0, dout);
        check("dec_roundtrip", dout, pt[b]);
      end
      do_done(t2);
      check("dec_tag", 512'(t2), 512'(exp_t));
    end

    // init and next together, then next/done while busy: only the init is taken
    do_reset();
    key = k1; nonce = n1; data_in = d1; encdec = 1'b1;
    init = 1'b1; next = 1'b1;
    tick();
    init = 1'b0; next = 1'b0;
    v0 = vcount;
    for (int i = 0; i < 20; i++) begin
      next = (i == 5);
      done = (i == 9);
      tick();
    end
    next = 1'b0; done = 1'b0;
    check("busy_ready_low", 512'(ready), 512'd0);
    tick();
    check("busy_ready_back", 512'(ready), 512'd1);
    check("busy_no_valid", 512'(vcount - v0), 512'd0);
    do_next(d1, 1'b1, dout);
    exp_d = d1 ^ m_ks(k1, n1, 32'd1);
    check("busy_counter1", dout, exp_d);
    do_done(t);
    check("busy_tag", 512'(t), 512'(m_tag(k1, n1, exp_d, 512'd0, 1)));

    // reset while absorbing a block, with a tag already held
    data_in = d1; encdec = 1'b1; next = 1'b1;
    tick();
    next = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    check("poly_busy", 512'(ready), 512'd0);
    check("poly_tag_held", 512'(tag_ok), 512'd1);
    do_reset();
    check("mid_rst_ready", 512'(ready), 512'd1);
    check("mid_rst_valid", 512'(valid), 512'd0);
    check("mid_rst_tag_ok", 512'(tag_ok), 512'd0);
    check("mid_rst_tag", 512'(tag), 512'd0);
    check("mid_rst_data_out", data_out, 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
